// File: rtl/hex_display_arbiter.sv
// hex_display_arbiter: round-robin time-sharing of one 4-digit hex display with a minimum dwell per grant.
// Optional owner tag on values[15:12] enabled by defining HEX_ARB_OWNER_TAG_EN.
module hex_display_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DWELL_CYCLES = 25_000_000,
  parameter logic [15:0] IDLE_VALUE = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [16*NUM_REQ-1:0] data,
  output logic [15:0]           values,
  output logic [NUM_REQ-1:0]    grant,
  output logic [2:0]            owner,
  output logic                  busy
);
  localparam int CW = DWELL_CYCLES > 1 ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DWELL_CYCLES - 1);
  typedef enum logic {IDLE, DWELL} state_t;
  state_t state;
  logic [2:0] ptr;
  logic [CW-1:0] cnt;
  logic sel_found, hand_found, owner_req;
  logic [2:0] sel_idx, hand_idx;
  logic [15:0] sel_data, hand_data, owner_data;
  logic [15:0] sel_show, hand_show, live_show;
  function automatic logic [2:0] wrap(input logic [2:0] base, input int k);
    logic [3:0] s;
    s = {1'b0, base} + 4'(k);
    return (s >= 4'(NUM_REQ)) ? 3'(s - 4'(NUM_REQ)) : s[2:0];
  endfunction
  function automatic logic [2:0] next_ptr(input logic [2:0] o);
    return (o == 3'(NUM_REQ - 1)) ? 3'd0 : o + 3'd1;
  endfunction
  function automatic logic [NUM_REQ-1:0] one_hot(input logic [2:0] o);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << o;
  endfunction
  // Search order: from ptr for a fresh grant, from owner+1 (owner excluded) for handover.
  always_comb begin
    sel_found = 1'b0;
    sel_idx = 3'd0;
    hand_found = 1'b0;
    hand_idx = 3'd0;
    for (int k = 0; k < NUM_REQ; k++)
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!sel_found && req[i] && 3'(i) == wrap(ptr, k)) begin
          sel_found = 1'b1;
          sel_idx = 3'(i);
        end
        if (k > 0 && !hand_found && req[i] && 3'(i) == wrap(owner, k)) begin
          hand_found = 1'b1;
          hand_idx = 3'(i);
        end
      end
  end
  always_comb begin
    owner_req = 1'b0;
    owner_data = '0;
    sel_data = '0;
    hand_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (3'(i) == owner) begin
        owner_req = req[i];
        owner_data = data[16*i +: 16];
      end
      if (3'(i) == sel_idx) sel_data = data[16*i +: 16];
      if (3'(i) == hand_idx) hand_data = data[16*i +: 16];
    end
  end
  always_comb begin
    sel_show = sel_data;
    hand_show = hand_data;
    live_show = owner_data;
`ifdef HEX_ARB_OWNER_TAG_EN
    sel_show[15:12] = {1'b0, sel_idx};
    hand_show[15:12] = {1'b0, hand_idx};
    live_show[15:12] = {1'b0, owner};
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      owner <= 3'd0;
      busy <= 1'b0;
      values <= IDLE_VALUE;
      ptr <= 3'd0;
      cnt <= '0;
    end else if (state == IDLE) begin
      if (sel_found) begin
        state <= DWELL;
        grant <= one_hot(sel_idx);
        owner <= sel_idx;
        busy <= 1'b1;
        values <= sel_show;
        ptr <= next_ptr(sel_idx);
        cnt <= RELOAD;
      end
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
      if (owner_req) values <= live_show;
    end else if (hand_found) begin
      grant <= one_hot(hand_idx);
      owner <= hand_idx;
      values <= hand_show;
      ptr <= next_ptr(hand_idx);
      cnt <= RELOAD;
    end else if (owner_req) begin
      values <= live_show;
      cnt <= RELOAD;
    end else begin
      state <= IDLE;
      grant <= '0;
      owner <= 3'd0;
      busy <= 1'b0;
      values <= IDLE_VALUE;
    end
  end
endmodule

// File: tb/tb_hex_display_arbiter.sv
// tb_hex_display_arbiter: directed checks of grant, rotation, dwell, freeze, reset and optional owner tag.
module tb_hex_display_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = '0;
  logic [63:0] data = '0;
  logic [15:0] values;
  logic [3:0] grant;
  logic [2:0] owner;
  logic busy;
  int checks = 0;
  int failures = 0;
`ifdef HEX_ARB_OWNER_TAG_EN
  localparam bit TAG = 1'b1;
`else
  localparam bit TAG = 1'b0;
`endif
  always #5 clk = ~clk;
  hex_display_arbiter #(.NUM_REQ(4), .DWELL_CYCLES(4), .IDLE_VALUE(16'h0000)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data),
    .values(values), .grant(grant), .owner(owner), .busy(busy)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] tv(input logic [15:0] v, input int o);
    return TAG ? {1'b0, 3'(o), v[11:0]} : v;
  endfunction
  task automatic expect_state(input string tag, input logic [3:0] g, input int o, input logic b, input logic [15:0] v);
    check({tag, "_grant"}, {12'b0, grant}, {12'b0, g});
    check({tag, "_owner"}, {13'b0, owner}, 16'(o));
    check({tag, "_busy"}, {15'b0, busy}, {15'b0, b});
    check({tag, "_values"}, values, v);
  endtask
  initial begin
    int seq[3] = '{0, 1, 3};
    int o;
    tick();
    expect_state("reset", 4'b0000, 0, 1'b0, 16'h0000);
    rst = 1'b0;
    req = 4'b0100;
    data[32 +: 16] = 16'hBEEF;
    tick();
    expect_state("single", 4'b0100, 2, 1'b1, tv(16'hBEEF, 2));
    for (int c = 0; c < 6; c++) begin
      tick();
      expect_state("renew", 4'b0100, 2, 1'b1, tv(16'hBEEF, 2));
    end
    rst = 1'b1;
    req = 4'b1011;
    data = {16'h3333, 16'h2222, 16'h1111, 16'h0AAA};
    tick();
    expect_state("rst_override", 4'b0000, 0, 1'b0, 16'h0000);
    rst = 1'b0;
    for (int c = 0; c < 16; c++) begin
      tick();
      o = seq[(c / 4) % 3];
      expect_state("rr", 4'b0001 << o, o, 1'b1, tv(data[16*o +: 16], o));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b0010;
    data[16 +: 16] = 16'h1234;
    tick();
    expect_state("own1", 4'b0010, 1, 1'b1, tv(16'h1234, 1));
    data[16 +: 16] = 16'h5678;
    tick();
    expect_state("live", 4'b0010, 1, 1'b1, tv(16'h5678, 1));
    req = 4'b0000;
    data[16 +: 16] = 16'h9999;
    tick();
    expect_state("freeze_a", 4'b0010, 1, 1'b1, tv(16'h5678, 1));
    tick();
    expect_state("freeze_b", 4'b0010, 1, 1'b1, tv(16'h5678, 1));
    tick();
    expect_state("expire_idle", 4'b0000, 0, 1'b0, 16'h0000);
    req = 4'b0011;
    tick();
    expect_state("ptr_wrap", 4'b0001, 0, 1'b1, tv(16'h0AAA, 0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    expect_state("pre_rst", 4'b0001, 0, 1'b1, tv(16'h0AAA, 0));
    tick();
    rst = 1'b1;
    tick();
    expect_state("mid_rst", 4'b0000, 0, 1'b0, 16'h0000);
    rst = 1'b0;
    tick();
    expect_state("post_rst", 4'b0001, 0, 1'b1, tv(16'h0AAA, 0));
`ifdef HEX_ARB_OWNER_TAG_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1000;
    data[48 +: 16] = 16'hABCD;
    tick();
    expect_state("tag", 4'b1000, 3, 1'b1, 16'h3BCD);
    req = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      tick();
      expect_state("tag_freeze", 4'b1000, 3, 1'b1, 16'h3BCD);
    end
    tick();
    expect_state("tag_idle", 4'b0000, 0, 1'b0, 16'h0000);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/hex_display_arbiter.md
# hex_display_arbiter

Time-shares one 4-digit hex display, driven by `hex_driver`, between up to eight requesters. Each requester presents a 16-bit value and a request line. The block grants the display round-robin, holds each grant for a guaranteed minimum dwell time, and drives the registered 16-bit `values` bus into `hex_driver`. It sits between status-producing blocks (counters, debug taps, UART monitors) and the display driver.

## Interface
- `NUM_REQ`, 4 — number of requesters, legal range 2..8.
- `DWELL_CYCLES`, 25_000_000 — minimum grant length in clk cycles, ≥1; counter width is `$clog2(DWELL_CYCLES)`, minimum 1.
- `IDLE_VALUE`, 16'h0000 — value shown when no grant is active.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  NUM_REQ  per-requester display request, level-sensitive.
- `data`  in  16*NUM_REQ  flattened values; requester i owns bits [16*i+15 : 16*i].
- `values`  out  16  value for `hex_driver`, registered.
- `grant`  out  NUM_REQ  one-hot current owner, all zero when idle, registered.
- `owner`  out  3  binary index of current owner, 0 when idle, registered.
- `busy`  out  1  high while any grant is active.

## Operation
- States: IDLE and DWELL.
- Reset values:
  - state IDLE
  - `grant`=0, `owner`=0, `busy`=0
  - `values`=IDLE_VALUE
  - round-robin pointer=0, dwell counter=0
- IDLE:
  - If `req`≠0, select the first asserted requester searching upward (with wrap) from the pointer.
  - Load that requester's `grant` and `owner`, set `busy`, load the counter with DWELL_CYCLES-1, and go to DWELL.
  - `values` loads the selected requester's `data` in the same edge.
- DWELL, each cycle:
  - If `req[owner]`=1, `values` <= `data[owner]` (live tracking).
  - If `req[owner]`=0, `values` holds the last captured value (freeze).
  - The counter decrements while it is non-zero.
- DWELL with counter==0, evaluated on that cycle's `req`:
  - Another requester asserted: hand over to the first asserted requester searching from owner+1 with wrap, excluding the owner. Reload the counter and load its `data`. No idle cycle is inserted.
  - Only the owner asserted: keep the grant and reload the counter.
  - No requests: go to IDLE. `grant`=0, `busy`=0, `values`=IDLE_VALUE.
- On every new grant, the pointer is set to owner+1 mod NUM_REQ.
- Requests are never queued or latched; a request dropped before selection is lost.
- `data` of non-owners is ignored.
- `req` bits at index ≥NUM_REQ do not exist; owner arithmetic wraps modulo NUM_REQ.

## Timing
- Request-to-grant latency:
  - From IDLE: `req` sampled at edge t → `grant`/`owner`/`busy`/`values` valid after edge t.
  - From DWELL: the request waits for the current counter to expire.
- `values` update latency: one cycle from `data`.
- With contention, each grant lasts exactly DWELL_CYCLES cycles. With DWELL_CYCLES=1, ownership rotates every cycle.
- `grant` is always one-hot or zero and matches `owner` and `busy` every cycle.
- `rst` asserted mid-DWELL returns all outputs to reset values on that edge. `rst` overrides every other event.

## Configuration
- Macro `HEX_ARB_OWNER_TAG_EN`.
- Defined:
  - While `busy`=1, `values[15:12]` is replaced by `owner` zero-extended to 4 bits.
  - `values[11:0]` comes from the owner's data as above.
  - While idle, IDLE_VALUE is shown unmodified.
- Undefined: all 16 bits come from owner data or IDLE_VALUE; no tagging logic is synthesized.

## Test plan
Bench parameters: NUM_REQ=4, DWELL_CYCLES=4, IDLE_VALUE=16'h0000, macro undefined unless stated.
- After reset, hold `req`=4'b0100 with `data[2]`=16'hBEEF → one cycle later `grant`=4'b0100, `owner`=2, `busy`=1, `values`=16'hBEEF. The grant persists in 4-cycle renewals while `req` holds.
- `req`=4'b1011 held continuously from reset → owners 0,1,3,0,… each for exactly 4 cycles, with no idle cycle between grants.
- Owner 1 granted, `data[1]` changes 16'h1234→16'h5678 → `values` follows one cycle later. Owner drops `req` at dwell cycle 1 → `values` frozen at 16'h5678 until expiry. Then IDLE, `values`=16'h0000, `busy`=0.
- `rst` pulsed at dwell cycle 2 with `req`=4'b0011 → next cycle all outputs at reset values. Re-arbitration starts from pointer 0, granting requester 0.
- Macro defined, `req`=4'b1000, `data[3]`=16'hABCD → `values`=16'h3BCD. After `req` drops and dwell expires, `values`=16'h0000.
